cpu_ctrl_unit_v2: RTL and testbench
===================================

# cpu_ctrl_unit_v2

Main decoder and ALU decoder for the pipelined RV32I CPU. It sits in the decode stage. It turns an instruction's opcode, funct3 and funct7[5] into the datapath control word: jump/branch flags, ALU operand selects, write enables, immediate format, ALU operation and result-mux select. The word is driven straight to the ID/EX pipeline register, or through an optional internal output register.

## Interface
- No parameters.
- Clocking is fixed: one clock, `clk`. Reset is `rst`, which is synchronous and active-high.
- `clk` — input, 1 bit — system clock; used only when the output register is compiled in.
- `rst` — input, 1 bit — synchronous, active-high reset of the output register.
- `opc` — input, 7 bits, type `cpu_opcode_t` — instruction bits [6:0].
- `funct3` — input, 3 bits — instruction bits [14:12].
- `funct7` — input, 1 bit — instruction bit 30 (funct7[5]).
- `jmp` — output, 1 bit — unconditional jump (JAL/JALR).
- `bra` — output, 1 bit — conditional branch.
- `alu_a_src` — output, 2 bits — ALU operand A: 00=rs1, 10=zero, 11=PC.
- `alu_b_src` — output, 1 bit — ALU operand B: 0=rs2, 1=immediate.
- `mem_wr_en` — output, 1 bit — data memory write enable.
- `regfl_wr_en` — output, 1 bit — register file write enable.
- `imd_src` — output, 3 bits — immediate format: 000=I, 001=S, 010=B, 011=J, 100=U.
- `alu_op_sel` — output, 4 bits — ALU operation (package encoding).
- `result_src` — output, 2 bits — writeback source: 00=ALU, 01=memory, 10=PC+4.

## Operation
- **Main decode.** The opcode produces the word {jmp, bra, alu_a_src, alu_b_src, mem_wr_en, regfl_wr_en, imd_src, alu_op[1:0], result_src}:
  - LOAD 0000011: 0,0,00,1,0,1,000,00,01
  - AUI_PC 0010111: 0,0,11,1,0,1,100,00,00
  - LUI 0110111: 0,0,10,1,0,1,100,00,00
  - JALR 1100111: 1,0,00,1,0,1,000,00,10
  - S_TYPE 0100011: 0,0,00,1,1,0,001,00,00
  - R_TYPE 0110011: 0,0,00,0,0,1,000,10,00
  - I_TYPE 0010011: 0,0,00,1,0,1,000,10,00
  - J_TYPE 1101111: 1,0,11,1,0,1,011,00,10
  - B_TYPE 1100063 is not valid; B_TYPE is 1100011: 0,1,00,0,0,0,010,01,00
  - Any other opcode: all fields 0. This is a NOP: no writes, ALU=ADD.
- **ALU decode.** alu_op 00 selects ADD. alu_op 01 selects SUB. For alu_op 10, funct3 selects:
  - 000: SUB when (opc[5] & funct7), otherwise ADD. ADDI with bit 30 set therefore stays ADD.
  - 001: SLL; 010: SLT; 011: SLTU; 100: XOR.
  - 101: SRA when funct7, otherwise SRL. This applies to both R and I forms.
  - 110: OR; 111: AND.
- Internal alu_op value 11 maps to ADD. It is never produced by the main decoder.
- Decoding is fully combinational and has no internal state other than the optional output register. Every input combination yields defined outputs with no X.

## Timing
- Without the output register: all outputs are a pure function of the current inputs, with zero-cycle latency. `clk` and `rst` are ignored.
- With the output register: the outputs are the decode of the inputs sampled at the previous `clk` rising edge, so latency is one cycle.
  - `rst` high at an edge loads all outputs with 0, which is a NOP (alu_op_sel=ADD=0000).
  - `rst` takes priority over new inputs.
  - Asserting `rst` mid-stream drops the in-flight decode.
- There is no handshake and no stall input. Stall and flush are handled by the ID/EX register outside this block.

## Configuration
- Macro: `CPU_CTRLU_OUT_REG_EN`.
- When defined: the full control word is registered on `clk` with synchronous `rst`, giving one cycle of latency.
- When undefined: the outputs are combinational and the `clk`/`rst` ports remain but are unused.

## Structure
- Shared package `pkg_cpu_typedefs` holds:
  - `cpu_opcode_t`: a 7-bit enum of the nine opcodes above.
  - The ALU enum: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001.
- One sub-module, `cpu_alu_decoder`, maps (alu_op, funct3, funct7, opc[5]) to alu_op_sel. The main decoder lives in the top module.

## Test plan
- R_TYPE, funct3=000, funct7=1 -> jmp=0, bra=0, alu_a_src=00, alu_b_src=0, regfl_wr_en=1, imd_src=000, alu_op_sel=SUB, result_src=00.
- I_TYPE, funct3=000, funct7=1 -> alu_op_sel=ADD, alu_b_src=1.
- I_TYPE, funct3=101, funct7=1 -> alu_op_sel=SRA.
- I_TYPE, funct3=101, funct7=0 -> alu_op_sel=SRL.
- J_TYPE -> jmp=1, alu_a_src=11, imd_src=011, result_src=10.
- B_TYPE -> bra=1, alu_op_sel=SUB, imd_src=010, regfl_wr_en=0.
- S_TYPE -> mem_wr_en=1, regfl_wr_en=0, imd_src=001.
- LUI -> alu_a_src=10, imd_src=100.
- Undefined opcode 0000000 -> all outputs 0.
- With `CPU_CTRLU_OUT_REG_EN`: drive LOAD; after one edge result_src=01. Then assert `rst` for one edge -> all outputs 0 on the following cycle.
- 5000 random opc/funct3/funct7 vectors compared against a reference model -> 0 mismatches.

Source files
------------

// File: rtl/pkg_cpu_typedefs.sv
// rtl/pkg_cpu_typedefs.sv - shared types for the RV32I decode-stage control unit
//
// Purpose : opcode enum, ALU operation enum, internal main-decoder alu_op
//           codes and the packed control words passed between the main
//           decoder, the ALU decoder and the output stage.
// Ports   : none (package).

package pkg_cpu_typedefs;

    // Major opcodes (instruction bits [6:0]) recognised by the main decoder.
    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_AUI_PC = 7'b0010111,
        OPC_LUI    = 7'b0110111,
        OPC_JALR   = 7'b1100111,
        OPC_S_TYPE = 7'b0100011,
        OPC_R_TYPE = 7'b0110011,
        OPC_I_TYPE = 7'b0010011,
        OPC_J_TYPE = 7'b1101111,
        OPC_B_TYPE = 7'b1100011
    } cpu_opcode_t;

    // ALU operation select seen by the execute stage.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } cpu_alu_op_t;

    // Coarse ALU class produced by the main decoder; 11 is unused and
    // treated as ADD by the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Operand / immediate / writeback select encodings.
    localparam logic [1:0] A_SRC_RS1  = 2'b00;
    localparam logic [1:0] A_SRC_ZERO = 2'b10;
    localparam logic [1:0] A_SRC_PC   = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Main-decoder output, before ALU decode.
    typedef struct packed {
        logic       jmp;
        logic       bra;
        logic [1:0] alu_a_src;
        logic       alu_b_src;
        logic       mem_wr_en;
        logic       regfl_wr_en;
        logic [2:0] imd_src;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } main_ctrl_t;

    // Complete control word as driven to the ID/EX register.
    typedef struct packed {
        logic        jmp;
        logic        bra;
        logic [1:0]  alu_a_src;
        logic        alu_b_src;
        logic        mem_wr_en;
        logic        regfl_wr_en;
        logic [2:0]  imd_src;
        cpu_alu_op_t alu_op_sel;
        logic [1:0]  result_src;
    } ctrl_word_t;

    // Builds a main-decoder word from its fields; keeps the opcode table
    // in the top readable as one row per instruction class.
    function automatic main_ctrl_t mk_main(
        input logic       jmp,
        input logic       bra,
        input logic [1:0] a_src,
        input logic       b_src,
        input logic       mem_wr,
        input logic       reg_wr,
        input logic [2:0] imd,
        input logic [1:0] alu_op,
        input logic [1:0] res
    );
        main_ctrl_t w;
        w.jmp         = jmp;
        w.bra         = bra;
        w.alu_a_src   = a_src;
        w.alu_b_src   = b_src;
        w.mem_wr_en   = mem_wr;
        w.regfl_wr_en = reg_wr;
        w.imd_src     = imd;
        w.alu_op      = alu_op;
        w.result_src  = res;
        return w;
    endfunction

endpackage

// File: rtl/cpu_ctrl_unit_v2_alu_decoder.sv
// rtl/cpu_ctrl_unit_v2_alu_decoder.sv - ALU operation decoder for the control unit
//
// Purpose : maps the main decoder's coarse alu_op plus funct3/funct7[5]
//           and opcode bit 5 onto the execute-stage ALU operation.
// Ports   : alu_op     [1:0] in  - coarse class: 00 ADD, 01 SUB, 10 by funct3, 11 ADD
//           funct3     [2:0] in  - instruction bits [14:12]
//           funct7           in  - instruction bit 30
//           opc_b5           in  - opcode bit 5 (1 = register-register form)
//           alu_op_sel [3:0] out - ALU operation, cpu_alu_op_t encoding

module cpu_alu_decoder
    import pkg_cpu_typedefs::*;
(
    input  logic [1:0]  alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  logic        opc_b5,
    output cpu_alu_op_t alu_op_sel
);

    always_comb begin
        alu_op_sel = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_op_sel = ALU_ADD;
            ALUOP_SUB: alu_op_sel = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Bit 30 only means SUB for the register form; ADDI
                    // carries immediate bits there.
                    3'b000:  alu_op_sel = (opc_b5 && funct7) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_sel = ALU_SLL;
                    3'b010:  alu_op_sel = ALU_SLT;
                    3'b011:  alu_op_sel = ALU_SLTU;
                    3'b100:  alu_op_sel = ALU_XOR;
                    // SRAI/SRA share bit 30 as the arithmetic flag.
                    3'b101:  alu_op_sel = funct7 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_sel = ALU_OR;
                    default: alu_op_sel = ALU_AND;
                endcase
            end
            default: alu_op_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_unit_v2.sv
// rtl/cpu_ctrl_unit_v2.sv - RV32I decode-stage main decoder and control word
//
// Purpose : decodes opcode/funct3/funct7[5] into the datapath control word.
//           Build option CPU_CTRLU_OUT_REG_EN registers the full word on clk
//           (sync active-high rst loads a NOP); otherwise the word is
//           combinational and clk/rst are unused.
// Ports   : clk, rst            in  - clock / synchronous active-high reset
//           opc          [6:0]  in  - instruction bits [6:0]
//           funct3       [2:0]  in  - instruction bits [14:12]
//           funct7              in  - instruction bit 30
//           jmp, bra            out - jump / conditional branch
//           alu_a_src    [1:0]  out - 00 rs1, 10 zero, 11 PC
//           alu_b_src           out - 0 rs2, 1 immediate
//           mem_wr_en           out - data memory write
//           regfl_wr_en         out - register file write
//           imd_src      [2:0]  out - 000 I, 001 S, 010 B, 011 J, 100 U
//           alu_op_sel   [3:0]  out - ALU operation
//           result_src   [1:0]  out - 00 ALU, 01 memory, 10 PC+4

module cpu_ctrl_unit_v2
    import pkg_cpu_typedefs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  cpu_opcode_t opc,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    output logic        jmp,
    output logic        bra,
    output logic [1:0]  alu_a_src,
    output logic        alu_b_src,
    output logic        mem_wr_en,
    output logic        regfl_wr_en,
    output logic [2:0]  imd_src,
    output logic [3:0]  alu_op_sel,
    output logic [1:0]  result_src
);

    main_ctrl_t  main_ctrl;
    cpu_alu_op_t alu_sel;
    ctrl_word_t  word_d;
    ctrl_word_t  word_o;

    // Main decoder: one row per opcode class. Unknown opcodes fall back to
    // an all-zero word, which is a NOP (no writes, ALU=ADD).
    always_comb begin
        main_ctrl = '0;
        case (opc)
            //                           jmp   bra   a_src       b_src mw    rw    imd    alu_op       result
            OPC_LOAD:   main_ctrl = mk_main(1'b0, 1'b0, A_SRC_RS1,  1'b1, 1'b0, 1'b1, IMM_I, ALUOP_ADD,   RES_MEM);
            OPC_AUI_PC: main_ctrl = mk_main(1'b0, 1'b0, A_SRC_PC,   1'b1, 1'b0, 1'b1, IMM_U, ALUOP_ADD,   RES_ALU);
            OPC_LUI:    main_ctrl = mk_main(1'b0, 1'b0, A_SRC_ZERO, 1'b1, 1'b0, 1'b1, IMM_U, ALUOP_ADD,   RES_ALU);
            OPC_JALR:   main_ctrl = mk_main(1'b1, 1'b0, A_SRC_RS1,  1'b1, 1'b0, 1'b1, IMM_I, ALUOP_ADD,   RES_PC4);
            OPC_S_TYPE: main_ctrl = mk_main(1'b0, 1'b0, A_SRC_RS1,  1'b1, 1'b1, 1'b0, IMM_S, ALUOP_ADD,   RES_ALU);
            OPC_R_TYPE: main_ctrl = mk_main(1'b0, 1'b0, A_SRC_RS1,  1'b0, 1'b0, 1'b1, IMM_I, ALUOP_FUNCT, RES_ALU);
            OPC_I_TYPE: main_ctrl = mk_main(1'b0, 1'b0, A_SRC_RS1,  1'b1, 1'b0, 1'b1, IMM_I, ALUOP_FUNCT, RES_ALU);
            OPC_J_TYPE: main_ctrl = mk_main(1'b1, 1'b0, A_SRC_PC,   1'b1, 1'b0, 1'b1, IMM_J, ALUOP_ADD,   RES_PC4);
            OPC_B_TYPE: main_ctrl = mk_main(1'b0, 1'b1, A_SRC_RS1,  1'b0, 1'b0, 1'b0, IMM_B, ALUOP_SUB,   RES_ALU);
            default:    main_ctrl = '0;
        endcase
    end

    cpu_alu_decoder u_alu_dec (
        .alu_op     (main_ctrl.alu_op),
        .funct3     (funct3),
        .funct7     (funct7),
        .opc_b5     (opc[5]),
        .alu_op_sel (alu_sel)
    );

    always_comb begin
        word_d             = '0;
        word_d.jmp         = main_ctrl.jmp;
        word_d.bra         = main_ctrl.bra;
        word_d.alu_a_src   = main_ctrl.alu_a_src;
        word_d.alu_b_src   = main_ctrl.alu_b_src;
        word_d.mem_wr_en   = main_ctrl.mem_wr_en;
        word_d.regfl_wr_en = main_ctrl.regfl_wr_en;
        word_d.imd_src     = main_ctrl.imd_src;
        word_d.alu_op_sel  = alu_sel;
        word_d.result_src  = main_ctrl.result_src;
    end

`ifdef CPU_CTRLU_OUT_REG_EN
    ctrl_word_t word_q;

    // Reset wins over the incoming decode, so an in-flight word is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign word_o         = word_d;
`endif

    assign jmp         = word_o.jmp;
    assign bra         = word_o.bra;
    assign alu_a_src   = word_o.alu_a_src;
    assign alu_b_src   = word_o.alu_b_src;
    assign mem_wr_en   = word_o.mem_wr_en;
    assign regfl_wr_en = word_o.regfl_wr_en;
    assign imd_src     = word_o.imd_src;
    assign alu_op_sel  = word_o.alu_op_sel;
    assign result_src  = word_o.result_src;

endmodule

// File: tb/tb_cpu_ctrl_unit_v2.sv
// tb/tb_cpu_ctrl_unit_v2.sv - self-checking bench for cpu_ctrl_unit_v2

module tb_cpu_ctrl_unit_v2;
    import pkg_cpu_typedefs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    cpu_opcode_t opc;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7 = 1'b0;
    logic        jmp, bra, alu_b_src, mem_wr_en, regfl_wr_en;
    logic [1:0]  alu_a_src, result_src;
    logic [2:0]  imd_src;
    logic [3:0]  alu_op_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_ctrl_unit_v2 dut (
        .clk         (clk),
        .rst         (rst),
        .opc         (opc),
        .funct3      (funct3),
        .funct7      (funct7),
        .jmp         (jmp),
        .bra         (bra),
        .alu_a_src   (alu_a_src),
        .alu_b_src   (alu_b_src),
        .mem_wr_en   (mem_wr_en),
        .regfl_wr_en (regfl_wr_en),
        .imd_src     (imd_src),
        .alu_op_sel  (alu_op_sel),
        .result_src  (result_src)
    );

    // Observed word: {jmp,bra,a_src,b_src,mw,rw,imd,alu_sel,res}
    logic [15:0] obs;
    assign obs = {jmp, bra, alu_a_src, alu_b_src, mem_wr_en, regfl_wr_en,
                  imd_src, alu_op_sel, result_src};

    // ALU codes written out independently of the package.
    localparam logic [3:0] E_ADD = 4'd0, E_SUB = 4'd1, E_AND = 4'd2, E_OR = 4'd3,
                           E_XOR = 4'd4, E_SLL = 4'd5, E_SRL = 4'd6, E_SRA = 4'd7,
                           E_SLT = 4'd8, E_SLTU = 4'd9;

    // Instruction table: opcode and {jmp,bra,a_src,b_src,mw,rw,imd,res}.
    logic [6:0]  tab_opc [9] = '{7'b0000011, 7'b0010111, 7'b0110111, 7'b1100111,
                                 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                                 7'b1100011};
    logic [11:0] tab_fld [9] = '{12'b0_0_00_1_0_1_000_01, 12'b0_0_11_1_0_1_100_00,
                                 12'b0_0_10_1_0_1_100_00, 12'b1_0_00_1_0_1_000_10,
                                 12'b0_0_00_1_1_0_001_00, 12'b0_0_00_0_0_1_000_00,
                                 12'b0_0_00_1_0_1_000_00, 12'b1_0_11_1_0_1_011_10,
                                 12'b0_1_00_0_0_0_010_00};
    // Arithmetic op by funct3 before funct7 modifiers.
    logic [3:0]  arith_f3 [8] = '{E_ADD, E_SLL, E_SLT, E_SLTU, E_XOR, E_SRL, E_OR, E_AND};

    function automatic logic [15:0] model(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7);
        logic [11:0] f   = '0;
        logic [3:0]  alu = E_ADD;
        for (int i = 0; i < 9; i++)
            if (tab_opc[i] == o) f = tab_fld[i];
        if (o == 7'b0110011 || o == 7'b0010011) begin
            alu = arith_f3[f3];
            if (f3 == 3'd0 && o == 7'b0110011 && f7) alu = E_SUB;
            if (f3 == 3'd5 && f7) alu = E_SRA;
        end else if (o == 7'b1100011) begin
            alu = E_SUB;
        end
        return {f[11:2], alu, f[1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Apply inputs just after an edge; sample 1 ns after the next edge.
    // Works for both the combinational and the registered build.
    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        opc    = cpu_opcode_t'(o);
        funct3 = f3;
        funct7 = f7;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] o;
        logic [2:0] f3;
        logic       f7;

        // Reset state / rst priority.
        drive(7'b0000011, 3'd0, 1'b0);
`ifdef CPU_CTRLU_OUT_REG_EN
        chk("reset_word", 32'(obs), 32'h0);
`else
        chk("rst_ignored", 32'(obs), 32'(model(7'b0000011, 3'd0, 1'b0)));
`endif
        rst = 1'b0;

        drive(7'b0110011, 3'd0, 1'b1);
        chk("r_sub_word", 32'(obs), 32'(16'b0_0_00_0_0_1_000_0001_00));
        drive(7'b0010011, 3'd0, 1'b1);
        chk("addi_b30_alu", 32'(alu_op_sel), 32'(E_ADD));
        chk("addi_b_src", 32'(alu_b_src), 32'd1);
        drive(7'b0010011, 3'd5, 1'b1);
        chk("srai", 32'(alu_op_sel), 32'(E_SRA));
        drive(7'b0010011, 3'd5, 1'b0);
        chk("srli", 32'(alu_op_sel), 32'(E_SRL));
        drive(7'b1101111, 3'd3, 1'b1);
        chk("jal", 32'({jmp, alu_a_src, imd_src, result_src}), 32'({1'b1, 2'b11, 3'b011, 2'b10}));
        drive(7'b1100011, 3'd1, 1'b0);
        chk("branch", 32'({bra, alu_op_sel, imd_src, regfl_wr_en}), 32'({1'b1, E_SUB, 3'b010, 1'b0}));
        drive(7'b0100011, 3'd2, 1'b1);
        chk("store", 32'({mem_wr_en, regfl_wr_en, imd_src}), 32'({1'b1, 1'b0, 3'b001}));
        drive(7'b0110111, 3'd7, 1'b1);
        chk("lui", 32'({alu_a_src, imd_src}), 32'({2'b10, 3'b100}));
        drive(7'b0000000, 3'd5, 1'b1);
        chk("undef_nop", 32'(obs), 32'h0);
        drive(7'b1100111, 3'd0, 1'b0);
        chk("jalr_word", 32'(obs), 32'(16'b1_0_00_1_0_1_000_0000_10));

        // Load, then a mid-stream reset.
        drive(7'b0000011, 3'd2, 1'b0);
        chk("load_res", 32'(result_src), 32'(2'b01));
        rst = 1'b1;
        drive(7'b0110011, 3'd4, 1'b0);
`ifdef CPU_CTRLU_OUT_REG_EN
        chk("mid_rst_nop", 32'(obs), 32'h0);
`else
        chk("mid_rst_comb", 32'(obs), 32'(model(7'b0110011, 3'd4, 1'b0)));
`endif
        rst = 1'b0;
        drive(7'b0010011, 3'd6, 1'b0);
        chk("after_rst", 32'(obs), 32'(16'b0_0_00_1_0_1_000_0011_00));

        // Random sweep: half valid opcodes, half arbitrary 7-bit values.
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 1) == 1)
                o = tab_opc[$urandom_range(0, 8)];
            else
                o = 7'($urandom);
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            drive(o, f3, f7);
            chk("rand", 32'(obs), 32'(model(o, f3, f7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
